alu_issue_ctrl: RTL and testbench

Instruction-side driver for the 32-bit ALU. It accepts one decoded-instruction request per valid/ready handshake. It turns opcode/funct into the ALU's 4-bit control code and selects the second operand (register or extended immediate). It registers the operands and code onto the ALU inputs, captures the ALU result and zero flag one cycle later, and returns result, branch decision and illegal flag through a response handshake. It sits between the control path and the ALU.

---
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Decodes one instruction request per handshake into ALU operands and control code,
// captures the ALU result one cycle later and returns it through a response handshake.
//
// state | meaning
// IDLE  | no op in flight, ready for a request
// EXEC  | operands on the ALU, result captured on the closing edge
// RESP  | response presented, held until resp_ready
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  ALUctl,
  input  logic [31:0] ALUOut,
  input  logic [1:0]  zero,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] result,
  output logic        branch_taken,
  output logic        illegal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [1:0]  state;
  logic        br_eq;
  logic        br_ne;
  logic        accept;
  logic        dec_ill;
  logic        dec_beq;
  logic        dec_bne;
  logic [3:0]  dec_ctl;
  logic [31:0] dec_b;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_zero;

  assign unused_zero = zero[1];
  assign imm_sext    = {{16{imm[15]}}, imm};
  assign imm_zext    = {16'h0000, imm};

  assign req_ready  = (state == IDLE) || ((state == RESP) && resp_ready);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  always_comb begin
    dec_ill = 1'b0;
    dec_beq = 1'b0;
    dec_bne = 1'b0;
    dec_ctl = CTL_ADD;
    dec_b   = rt_val;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          6'b100000: dec_ctl = CTL_ADD;
          6'b100010: dec_ctl = CTL_SUB;
          6'b100100: dec_ctl = CTL_AND;
          6'b100101: dec_ctl = CTL_OR;
          6'b101010: dec_ctl = CTL_SLT;
          default:   dec_ill = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        dec_ctl = CTL_ADD;
        dec_b   = imm_sext;
      end
      OP_SLTI: begin
        dec_ctl = CTL_SLT;
        dec_b   = imm_sext;
      end
      OP_ANDI: begin
        dec_ctl = CTL_AND;
        dec_b   = imm_zext;
      end
      OP_ORI: begin
        dec_ctl = CTL_OR;
        dec_b   = imm_zext;
      end
      OP_BEQ: begin
        dec_ctl = CTL_SUB;
        dec_beq = 1'b1;
      end
      OP_BNE: begin
        dec_ctl = CTL_SUB;
        dec_bne = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a            <= '0;
      b            <= '0;
      ALUctl       <= CTL_AND;
      br_eq        <= 1'b0;
      br_ne        <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          result       <= ALUOut;
          branch_taken <= (br_eq && zero[0]) || (br_ne && !zero[0]);
          illegal      <= 1'b0;
          state        <= RESP;
        end
        default: begin
          // IDLE and RESP share the accept path; RESP only accepts when resp_ready is high
          if (accept) begin
            if (dec_ill) begin
              illegal      <= 1'b1;
              result       <= '0;
              branch_taken <= 1'b0;
              state        <= RESP;
            end else begin
              a      <= rs_val;
              b      <= dec_b;
              ALUctl <= dec_ctl;
              br_eq  <= dec_beq;
              br_ne  <= dec_bne;
              state  <= EXEC;
            end
          end else if (state == RESP && resp_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a driver pushes expected responses from an
// instruction-level reference model, a negedge monitor pops and compares them.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [15:0] imm = '0;
  logic [31:0] a, b;
  logic [3:0]  ALUctl;
  logic [31:0] ALUOut;
  logic [1:0]  zero;
  logic        zero_hi = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          hs_times[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rr_mode = 0;
  bit          track_hs = 0;
  bit          prev_stall = 0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;
  logic [3:0]  exp_ctl = '0;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
    .a(a), .b(b), .ALUctl(ALUctl), .ALUOut(ALUOut), .zero(zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour seen by the controller
  always_comb begin
    case (ALUctl)
      4'b0000: ALUOut = a & b;
      4'b0001: ALUOut = a | b;
      4'b0010: ALUOut = a + b;
      4'b0110: ALUOut = a - b;
      4'b0111: ALUOut = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: ALUOut = 32'd0;
    endcase
  end
  assign zero = {zero_hi, (ALUOut == 32'd0)};

  always @(posedge clk) begin
    #1;
    zero_hi = 1'($urandom);
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = ($urandom_range(0, 9) < 7);
      default: resp_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: operation by name, plain arithmetic on operands
  function automatic void model(input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] im, output logic ill,
                                output logic [3:0] ctl, output logic [31:0] bv,
                                output logic [31:0] res, output logic br);
    int kind;
    logic [31:0] sx, zx;
    sx = {{16{im[15]}}, im};
    zx = {16'h0000, im};
    ill = 1'b0; br = 1'b0; bv = rt; kind = 0;
    case (op)
      6'd0: case (fn)
        6'b100000: kind = 0;
        6'b100010: kind = 1;
        6'b100100: kind = 2;
        6'b100101: kind = 3;
        6'b101010: kind = 4;
        default:   ill = 1'b1;
      endcase
      6'b001000, 6'b100011, 6'b101011: begin kind = 0; bv = sx; end
      6'b001010: begin kind = 4; bv = sx; end
      6'b001100: begin kind = 2; bv = zx; end
      6'b001101: begin kind = 3; bv = zx; end
      6'b000100: begin kind = 1; br = (rs == rt); end
      6'b000101: begin kind = 1; br = (rs != rt); end
      default: ill = 1'b1;
    endcase
    case (kind)
      0:       begin ctl = 4'b0010; res = rs + bv; end
      1:       begin ctl = 4'b0110; res = rs - bv; end
      2:       begin ctl = 4'b0000; res = rs & bv; end
      3:       begin ctl = 4'b0001; res = rs | bv; end
      default: begin ctl = 4'b0111; res = ($signed(rs) < $signed(bv)) ? 32'd1 : 32'd0; end
    endcase
    if (ill) begin
      res = 32'd0; br = 1'b0; ctl = 4'b0000;
    end
  endfunction

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] im);
    logic ill, br;
    logic [3:0] ctl;
    logic [31:0] bv, res;
    exp_t e;
    int t;
    model(op, fn, rs, rt, im, ill, ctl, bv, res, br);
    opcode = op; funct = fn; rs_val = rs; rt_val = rt; imm = im;
    req_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready && t < 200);
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.res = res; e.br = br; e.ill = ill;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    opcode = 6'($urandom); funct = 6'($urandom);
    rs_val = $urandom; rt_val = $urandom; imm = 16'($urandom);
    if (!ill) begin
      exp_a = rs; exp_b = bv; exp_ctl = ctl;
    end
    chk("a_after_accept", a, exp_a);
    chk("b_after_accept", b, exp_b);
    chk("ctl_after_accept", 32'(ALUctl), 32'(exp_ctl));
    chk("resp_valid_latency", 32'(resp_valid), 32'(ill));
    if (!ill) begin
      @(posedge clk);
      #1;
      chk("resp_valid_after_exec", 32'(resp_valid), 32'd1);
    end
  endtask

  task automatic reset_check();
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_ctl", 32'(ALUctl), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_branch", 32'(branch_taken), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    sb.delete();
    exp_a = '0; exp_b = '0; exp_ctl = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("resp_valid_held", 32'(resp_valid), 32'd1);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_without_request", 32'(resp_valid), 32'd0);
        end else begin
          chk("result", result, sb[0].res);
          chk("branch_taken", 32'(branch_taken), 32'(sb[0].br));
          chk("illegal", 32'(illegal), 32'(sb[0].ill));
          if (!resp_ready) begin
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_a", a, exp_a);
            chk("stall_b", b, exp_b);
            chk("stall_ctl", 32'(ALUctl), 32'(exp_ctl));
          end else begin
            void'(sb.pop_front());
            if (track_hs) hs_times.push_back(cyc);
          end
        end
      end
      prev_stall = resp_valid && !resp_ready;
    end
  end

  logic [5:0] op_tab[9] = '{6'b000000, 6'b001000, 6'b001010, 6'b001100, 6'b001101,
                            6'b100011, 6'b101011, 6'b000100, 6'b000101};
  logic [5:0] fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] op, fn;
    logic [31:0] rs, rt;
    int n;

    @(posedge clk);
    #2;
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_ctl", 32'(ALUctl), 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    rr_mode = 0;
    issue(6'b000000, 6'b100000, 32'd5, 32'd7, 16'h0000);
    issue(6'b001000, 6'b000000, 32'd3, 32'd0, 16'hFFFF);
    chk("addi_sext_b", b, 32'hFFFFFFFF);
    issue(6'b001101, 6'b000000, 32'h00000001, 32'd0, 16'h8000);
    chk("ori_zext_b", b, 32'h00008000);
    issue(6'b000100, 6'b000000, 32'h1234, 32'h1234, 16'h0);
    issue(6'b000101, 6'b000000, 32'h1234, 32'h1234, 16'h0);
    issue(6'b000101, 6'b000000, 32'd1, 32'd2, 16'h0);
    issue(6'b111111, 6'b100000, 32'd9, 32'd9, 16'h0);
    issue(6'b000000, 6'b000000, 32'd9, 32'd9, 16'h0);
    issue(6'b000000, 6'b100010, 32'd3, 32'd10, 16'h0);
    issue(6'b000000, 6'b101010, 32'hFFFFFFFE, 32'd1, 16'h0);
    issue(6'b001010, 6'b000000, 32'd0, 32'd0, 16'hFFFF);
    issue(6'b001100, 6'b000000, 32'hFFFFFFFF, 32'd0, 16'h8F0F);
    issue(6'b100011, 6'b000000, 32'h100, 32'd0, 16'hFFF0);
    issue(6'b101011, 6'b000000, 32'h100, 32'd0, 16'h0010);
    drain();

    // reset while the op is in EXEC: no response may follow
    opcode = 6'b000000; funct = 6'b100000; rs_val = 32'd20; rt_val = 32'd22;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("exec_resp_valid", 32'(resp_valid), 32'd0);
    chk("exec_ctl", 32'(ALUctl), 32'b0010);
    reset_check();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_resp_after_reset", 32'(resp_valid), 32'd0);
    end

    // back-to-back adds with the first response stalled
    rr_mode = 2;
    track_hs = 1;
    fork
      begin
        issue(6'b000000, 6'b100000, 32'd1, 32'd2, 16'h0);
        issue(6'b000000, 6'b100000, 32'd30, 32'd40, 16'h0);
        issue(6'b000000, 6'b100000, 32'hFFFFFFFF, 32'd2, 16'h0);
      end
      begin
        int t;
        t = 0;
        while (!resp_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        chk("b2b_first_resp", 32'(resp_valid), 32'd1);
        repeat (3) @(negedge clk);
        rr_mode = 0;
      end
    join
    drain();
    track_hs = 0;
    chk("b2b_hs_count", 32'(hs_times.size()), 32'd3);
    if (hs_times.size() >= 3) begin
      chk("b2b_interval_1", 32'(hs_times[1] - hs_times[0]), 32'd2);
      chk("b2b_interval_2", 32'(hs_times[2] - hs_times[1]), 32'd2);
    end

    rr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 10);
      op = (n < 9) ? op_tab[n] : 6'($urandom);
      n = $urandom_range(0, 5);
      fn = (n < 5) ? fn_tab[n] : 6'($urandom);
      rs = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 8)) - 32'd4 : $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      issue(op, fn, rs, rt, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rr_mode = 0;
    drain();

    // reset while a response is stalled in RESP
    rr_mode = 2;
    issue(6'b001000, 6'b000000, 32'd100, 32'd0, 16'h0005);
    chk("resp_before_reset", 32'(resp_valid), 32'd1);
    chk("result_before_reset", result, 32'd105);
    reset_check();
    rr_mode = 0;
    issue(6'b000000, 6'b100101, 32'hF0, 32'h0F, 16'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
